// File: rtl/ram_req_pkg.sv
// Shared helpers and request type for the RAM port requester.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ram_req_pkg;

    localparam int unsigned REQ_ADDR_WIDTH = 8;
    localparam int unsigned REQ_NUM_BYTES  = 4;
    localparam int unsigned REQ_DATA_WIDTH = 32;

    // Request as seen on the handshake, at the default port geometry.
    typedef struct packed {
        logic [REQ_NUM_BYTES-1:0]  we;
        logic [REQ_ADDR_WIDTH-1:0] addr;
        logic [REQ_DATA_WIDTH-1:0] data;
    } ram_req_t;

    function automatic int unsigned ram_clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < value; v = v << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // RAM read latency: one base register plus the configured extra stages.
    function automatic int unsigned ram_lat(input int unsigned pipe_stages);
        return pipe_stages + 1;
    endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Response FIFO holding captured RAM read data in arrival order.
// Latency: a push is visible on the output the cycle after the push edge; no bypass.
// Backpressure: none internally; the caller's credit count guarantees a free slot on every push.
module ram_rsp_fifo
    import ram_req_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CW    = ram_clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic [CW-1:0]    count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? ram_clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             not_empty;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign not_empty = (cnt_q != '0);
    assign do_pop    = pop_i & not_empty;
    assign pop_dat_o = not_empty ? mem_q[rd_ptr_q] : '0;
    assign count_o   = cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/ram_port_requester.sv
// Drives one byte-write RAM port from a valid/ready request stream; optional stall counter under RAM_REQ_STALL_CNT_EN.
// Latency: RAM signals registered (+1); read data valid READ_PIPE_STAGES+2 cycles after acceptance.
// Backpressure: req_ready_o drops when in-flight reads plus queued responses reach RSP_DEPTH.
module ram_port_requester
    import ram_req_pkg::*;
#(
    parameter int unsigned READ_PIPE_STAGES = 0,
    parameter int unsigned ADDR_WIDTH       = 8,
    parameter int unsigned NUM_BYTES        = 4,
    parameter int unsigned BYTE_WIDTH       = 8,
    parameter int unsigned DATA_WIDTH       = NUM_BYTES * BYTE_WIDTH,
    parameter int unsigned RSP_DEPTH        = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [NUM_BYTES-1:0]  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic [NUM_BYTES-1:0]  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_din_o,
    input  logic [DATA_WIDTH-1:0] ram_dout_i
`ifdef RAM_REQ_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt_o
`endif
);

    localparam int unsigned LAT = ram_lat(READ_PIPE_STAGES);
    localparam int unsigned CW  = ram_clog2(RSP_DEPTH) + 1;

    typedef struct packed {
        logic [NUM_BYTES-1:0]  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    req_t          ram_q, ram_d;
    logic [LAT:0]  tag_q, tag_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [CW-1:0] fifo_count;
    logic          req_acc;
    logic          rd_acc;
    logic          rsp_pop;

    assign req_ready_o = rst_n_i & (credit_q < CW'(RSP_DEPTH));
    assign req_acc     = req_valid_i & req_ready_o;
    assign rd_acc      = req_acc & (req_we_i == '0);
    assign rsp_valid_o = (fifo_count != '0);
    assign rsp_pop     = rsp_valid_o & rsp_ready_i;

    assign ram_we_o    = ram_q.we;
    assign ram_addr_o  = ram_q.addr;
    assign ram_din_o   = ram_q.data;

    always_comb begin
        ram_d    = ram_q;
        ram_d.we = '0;
        if (req_acc) begin
            ram_d.we   = req_we_i;
            ram_d.addr = req_addr_i;
            ram_d.data = req_data_i;
        end
        // One slot for the output register plus LAT for the RAM itself.
        tag_d    = {tag_q[LAT-1:0], rd_acc};
        credit_d = credit_q;
        case ({rd_acc, rsp_pop})
            2'b10:   credit_d = credit_q + 1'b1;
            2'b01:   credit_d = credit_q - 1'b1;
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ram_q    <= '0;
            tag_q    <= '0;
            credit_q <= '0;
        end else begin
            ram_q    <= ram_d;
            tag_q    <= tag_d;
            credit_q <= credit_d;
        end
    end

    ram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .push_i     (tag_q[LAT]),
        .push_dat_i (ram_dout_i),
        .pop_i      (rsp_pop),
        .pop_dat_o  (rsp_data_o),
        .count_o    (fifo_count)
    );

`ifdef RAM_REQ_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (req_valid_i && !req_ready_o && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule
